// File: rtl/gb_chan_bank.sv
// Bus-mapped bank of NCH channels (one CSR plus one small RAM each) with a user-side RAM read port.
// Optional feature macro: GB_CHAN_BANK_SHADOW_EN (shadowed CSRs, updated to csr_out on commit).
module gb_chan_bank #(
    parameter int unsigned      AW       = 24,
    parameter int unsigned      DW       = 32,
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      CSR_W    = 4,
    parameter logic [CSR_W-1:0] CSR_INIT = 4'hc,
    parameter int unsigned      RAM_AW   = 3,
    parameter int unsigned      RAM_DW   = 8,
    parameter logic [AW-1:0]    BASE     = '0,
    parameter int unsigned      RD       = 1,
    localparam int unsigned     CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   gb_clk,
    input  logic                   gb_rst,
    input  logic [AW-1:0]          gb_addr,
    input  logic [DW-1:0]          gb_wdata,
    input  logic                   gb_wen,
    input  logic                   gb_rstb,
    output logic [DW-1:0]          gb_rdata,
    output logic                   gb_rvalid,
    output logic                   bus_err,
    output logic [NCH*CSR_W-1:0]   csr_out,
    output logic [NCH-1:0]         csr_stb,
`ifdef GB_CHAN_BANK_SHADOW_EN
    input  logic                   commit,
`endif
    input  logic [CW-1:0]          usr_chan,
    input  logic [RAM_AW-1:0]      usr_addr,
    output logic [RAM_DW-1:0]      usr_rdata
);

    localparam int unsigned     DEPTH  = 1 << RAM_AW;
    localparam int unsigned     WIN    = (NCH + 1) * DEPTH;
    localparam int unsigned     XW     = AW + 1;
    localparam int unsigned     OW     = RAM_AW + 5;
    localparam logic [XW-1:0]   BASE_X = {1'b0, BASE};
    localparam logic [XW-1:0]   END_X  = BASE_X + XW'(WIN);

    logic [XW-1:0]     addr_x;
    logic [OW-1:0]     off;
    logic              in_win;
    logic [4:0]        region;
    logic [RAM_AW-1:0] word;
    logic              is_csr;
    logic              is_ram;
    logic              is_hole;
    logic [CW-1:0]     csr_idx;
    logic [CW-1:0]     ram_idx;
    logic              wr_fire;
    logic              rd_fire;
    logic [DW-1:0]     rd_word;

    logic [RAM_DW-1:0] mem_q [NCH][DEPTH];
    logic [CSR_W-1:0]  csr_q [NCH];
`ifdef GB_CHAN_BANK_SHADOW_EN
    logic [CSR_W-1:0]  shd_q [NCH];
`endif
    logic [NCH-1:0]    csr_stb_q;
    logic [RD-1:0]     pv_q;
    logic [DW-1:0]     pd_q [RD];
    logic              bus_err_q;
    logic [RAM_DW-1:0] usr_rdata_q;

    // Only the low CSR_W / RAM_DW bits of a write are stored.
    logic              unused_wdata;
    assign unused_wdata = ^gb_wdata;

    // Window decode: region 0 holds the CSRs (rest of it is a hole), region n+1 is RAM n.
    always_comb begin
        addr_x  = {1'b0, gb_addr};
        off     = OW'(addr_x - BASE_X);
        in_win  = (addr_x >= BASE_X) && (addr_x < END_X);
        region  = off[RAM_AW+4:RAM_AW];
        word    = off[RAM_AW-1:0];
        is_csr  = in_win && (region == 5'd0) && ({1'b0, word} < (RAM_AW+1)'(NCH));
        is_ram  = in_win && (region != 5'd0);
        is_hole = in_win && !is_csr && !is_ram;
        csr_idx = CW'(word);
        ram_idx = CW'(region - 5'd1);
        wr_fire = gb_wen && !gb_rst;
        rd_fire = gb_rstb && !gb_wen && !gb_rst && in_win;
    end

    always_comb begin
        rd_word = '0;
        if (is_csr) begin
`ifdef GB_CHAN_BANK_SHADOW_EN
            rd_word = DW'(shd_q[csr_idx]);
`else
            rd_word = DW'(csr_q[csr_idx]);
`endif
        end else if (is_ram) begin
            rd_word = DW'(mem_q[ram_idx][word]);
        end
    end

    // RAM contents survive reset; the user port sees pre-write data on a same-cycle collision.
    always_ff @(posedge gb_clk) begin
        if (wr_fire && is_ram) begin
            mem_q[ram_idx][word] <= gb_wdata[RAM_DW-1:0];
        end
        if (32'(usr_chan) < NCH) begin
            usr_rdata_q <= mem_q[usr_chan][usr_addr];
        end else begin
            usr_rdata_q <= '0;
        end
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                csr_q[n] <= CSR_INIT;
`ifdef GB_CHAN_BANK_SHADOW_EN
                shd_q[n] <= CSR_INIT;
`endif
            end
            csr_stb_q <= '0;
        end else begin
            csr_stb_q <= '0;
`ifdef GB_CHAN_BANK_SHADOW_EN
            // Commit copies the shadows as they were before any same-cycle write.
            if (commit) begin
                for (int unsigned n = 0; n < NCH; n++) begin
                    csr_q[n] <= shd_q[n];
                end
                csr_stb_q <= '1;
            end
            if (wr_fire && is_csr) begin
                shd_q[csr_idx] <= gb_wdata[CSR_W-1:0];
            end
`else
            if (wr_fire && is_csr) begin
                csr_q[csr_idx]     <= gb_wdata[CSR_W-1:0];
                csr_stb_q[csr_idx] <= 1'b1;
            end
`endif
        end
    end

    // Each stage loads data only with a valid token, so the last stage holds the last read.
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            pv_q      <= '0;
            bus_err_q <= 1'b0;
            for (int unsigned k = 0; k < RD; k++) begin
                pd_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= rd_fire;
            if (rd_fire) begin
                pd_q[0] <= rd_word;
            end
            for (int unsigned k = 1; k < RD; k++) begin
                pv_q[k] <= pv_q[k-1];
                if (pv_q[k-1]) begin
                    pd_q[k] <= pd_q[k-1];
                end
            end
            bus_err_q <= is_hole && (gb_wen || gb_rstb);
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_csr_out
        assign csr_out[n*CSR_W +: CSR_W] = csr_q[n];
    end

    assign csr_stb   = csr_stb_q;
    assign gb_rdata  = pd_q[RD-1];
    assign gb_rvalid = pv_q[RD-1];
    assign bus_err   = bus_err_q;
    assign usr_rdata = usr_rdata_q;

endmodule

// File: tb/tb_gb_chan_bank.sv
// Scoreboard bench for gb_chan_bank: two instances (RD=1 and RD=3) driven by the same bus stimulus.
`timescale 1ns/1ps
module tb_gb_chan_bank;

    localparam int unsigned AW     = 24;
    localparam int unsigned DW     = 32;
    localparam int unsigned NCH    = 4;
    localparam int unsigned CSR_W  = 4;
    localparam int unsigned RAM_AW = 3;
    localparam int unsigned RAM_DW = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WIN    = 40;
    localparam logic [3:0]  INIT   = 4'hc;

    logic          gb_clk = 1'b0;
    logic          gb_rst;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wen;
    logic          gb_rstb;
    logic          commit;
    logic [1:0]    usr_chan;
    logic [2:0]    usr_addr;

    logic [DW-1:0] rdata1, rdata3;
    logic          rv1, rv3, err1, err3;
    logic [15:0]   csr1, csr3;
    logic [3:0]    stb1, stb3;
    logic [7:0]    urd1, urd3;

    gb_chan_bank #(
        .AW(AW), .DW(DW), .NCH(NCH), .CSR_W(CSR_W), .CSR_INIT(INIT),
        .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .BASE(24'h0), .RD(1)
    ) u_rd1 (
        .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(rdata1), .gb_rvalid(rv1),
        .bus_err(err1), .csr_out(csr1), .csr_stb(stb1),
`ifdef GB_CHAN_BANK_SHADOW_EN
        .commit(commit),
`endif
        .usr_chan(usr_chan), .usr_addr(usr_addr), .usr_rdata(urd1)
    );

    gb_chan_bank #(
        .AW(AW), .DW(DW), .NCH(NCH), .CSR_W(CSR_W), .CSR_INIT(INIT),
        .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .BASE(24'h0), .RD(3)
    ) u_rd3 (
        .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(rdata3), .gb_rvalid(rv3),
        .bus_err(err3), .csr_out(csr3), .csr_stb(stb3),
`ifdef GB_CHAN_BANK_SHADOW_EN
        .commit(commit),
`endif
        .usr_chan(usr_chan), .usr_addr(usr_addr), .usr_rdata(urd3)
    );

    always #5 gb_clk = ~gb_clk;

    int unsigned cyc = 0;
    always @(posedge gb_clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [3:0] csr_m [NCH];
    logic [3:0] shd_m [NCH];
    logic [7:0] mem_m [NCH][DEPTH];
    bit         usr_on = 0;
    bit         mon_en = 0;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   issue;
    } rd_t;
    rd_t           q1[$];
    rd_t           q3[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last3 = '0;

    function automatic logic [3:0] csr_rd_m(input int unsigned n);
`ifdef GB_CHAN_BANK_SHADOW_EN
        return shd_m[n];
`else
        return csr_m[n];
`endif
    endfunction

    function automatic logic [15:0] csr_flat_m();
        return {csr_m[3], csr_m[2], csr_m[1], csr_m[0]};
    endfunction

    always @(posedge gb_clk) begin
        #1;
        if (mon_en) begin
            if (rv1) begin
                if (q1.size() == 0) begin
                    check_eq("rd1_spurious", {63'b0, rv1}, 64'd0);
                end else begin
                    rd_t e;
                    e = q1.pop_front();
                    check_eq("rd1_data", rdata1, e.data);
                    check_eq("rd1_latency", cyc - e.issue, 1);
                    last1 = e.data;
                end
            end else begin
                check_eq("rd1_hold", rdata1, last1);
            end
        end
    end

    always @(posedge gb_clk) begin
        #1;
        if (mon_en) begin
            if (rv3) begin
                if (q3.size() == 0) begin
                    check_eq("rd3_spurious", {63'b0, rv3}, 64'd0);
                end else begin
                    rd_t e;
                    e = q3.pop_front();
                    check_eq("rd3_data", rdata3, e.data);
                    check_eq("rd3_latency", cyc - e.issue, 3);
                    last3 = e.data;
                end
            end else begin
                check_eq("rd3_hold", rdata3, last3);
            end
        end
    end

    // One bus cycle: drive, predict, then check the registered side effects after the edge.
    task automatic bus_op(input logic wen, input logic rstb, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic cmt = 1'b0);
        int unsigned   off, ch, wd;
        bit            inwin, is_csr, is_ram, is_hole;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [3:0]    exp_stb;
        logic [7:0]    exp_usr;
        rd_t           e;
        @(negedge gb_clk);
        gb_wen   = wen;
        gb_rstb  = rstb;
        gb_addr  = addr;
        gb_wdata = wdata;
        commit   = cmt;
        off      = addr;
        inwin    = off < WIN;
        is_csr   = inwin && off < NCH;
        is_ram   = inwin && off >= DEPTH;
        is_hole  = inwin && !is_csr && !is_ram;
        wd       = off % DEPTH;
        ch       = is_ram ? off / DEPTH - 1 : (is_csr ? off : 0);
        exp_rd   = '0;
        if (is_csr) exp_rd = {28'b0, csr_rd_m(ch)};
        else if (is_ram) exp_rd = {24'b0, mem_m[ch][wd]};
        if (rstb && !wen && inwin) begin
            e.data  = exp_rd;
            e.issue = cyc;
            q1.push_back(e);
            q3.push_back(e);
        end
        exp_err = is_hole && (wen || rstb);
        exp_usr = mem_m[usr_chan][usr_addr];
        exp_stb = '0;
`ifdef GB_CHAN_BANK_SHADOW_EN
        if (cmt) begin
            for (int n = 0; n < NCH; n++) csr_m[n] = shd_m[n];
            exp_stb = '1;
        end
        if (wen && is_csr) shd_m[ch] = wdata[3:0];
`else
        if (wen && is_csr) begin
            csr_m[ch]   = wdata[3:0];
            exp_stb[ch] = 1'b1;
        end
`endif
        if (wen && is_ram) mem_m[ch][wd] = wdata[7:0];
        @(posedge gb_clk);
        #1;
        check_eq("bus_err1", err1, exp_err);
        check_eq("bus_err3", err3, exp_err);
        check_eq("csr_stb1", stb1, exp_stb);
        check_eq("csr_stb3", stb3, exp_stb);
        check_eq("csr_out1", csr1, csr_flat_m());
        check_eq("csr_out3", csr3, csr_flat_m());
        if (usr_on) begin
            check_eq("usr_rdata1", urd1, exp_usr);
            check_eq("usr_rdata3", urd3, exp_usr);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) bus_op(1'b0, 1'b0, '0, '0);
    endtask

    // Two reset cycles: the first carries a RAM write, the second a read; both must be dropped.
    task automatic do_reset();
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge gb_clk);
            gb_rst   = 1'b1;
            gb_wen   = (i == 0);
            gb_rstb  = (i == 1);
            gb_addr  = 24'h09;
            gb_wdata = 32'h0000_00ff;
            commit   = 1'b0;
            q1.delete();
            q3.delete();
            last1 = '0;
            last3 = '0;
            for (int n = 0; n < NCH; n++) begin
                csr_m[n] = INIT;
                shd_m[n] = INIT;
            end
            @(posedge gb_clk);
            #1;
            check_eq("rst_rvalid1", rv1, 1'b0);
            check_eq("rst_rvalid3", rv3, 1'b0);
            check_eq("rst_rdata1", rdata1, 32'h0);
            check_eq("rst_rdata3", rdata3, 32'h0);
            check_eq("rst_err1", err1, 1'b0);
            check_eq("rst_stb1", stb1, 4'h0);
            check_eq("rst_csr1", csr1, {4{INIT}});
            check_eq("rst_csr3", csr3, {4{INIT}});
        end
        @(negedge gb_clk);
        gb_rst  = 1'b0;
        gb_wen  = 1'b0;
        gb_rstb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by %0t, expected end of test", $time);
        $fatal(1);
    end

    initial begin
        gb_rst   = 1'b1;
        gb_wen   = 1'b0;
        gb_rstb  = 1'b0;
        gb_addr  = '0;
        gb_wdata = '0;
        commit   = 1'b0;
        usr_chan = '0;
        usr_addr = '0;

        do_reset();
        mon_en = 1;

        // Reset value of CSR 2
        bus_op(1'b0, 1'b1, 24'h02, '0);
        idle(3);

        // Fill every RAM word; upper wdata bits are garbage that must be dropped
        for (int unsigned a = DEPTH; a < WIN; a++) bus_op(1'b1, 1'b0, AW'(a), $urandom());
        usr_on = 1;

        // RAM 3 word 7 write with a same-cycle user read (old data), then bus and user read back
        usr_chan = 2'd3;
        usr_addr = 3'd7;
        bus_op(1'b1, 1'b0, 24'h27, 32'hABCD_EF5A);
        bus_op(1'b0, 1'b1, 24'h27, '0);
        idle(3);

        // Back-to-back reads of RAM 0
        for (int unsigned a = 8; a < 16; a++) begin
            usr_chan = 2'($urandom_range(0, 3));
            usr_addr = 3'($urandom_range(0, 7));
            bus_op(1'b0, 1'b1, AW'(a), '0);
        end
        idle(4);

        // CSR writes, including a rewrite of the same value
        bus_op(1'b1, 1'b0, 24'h00, 32'hFFFF_FFF1);
        bus_op(1'b1, 1'b0, 24'h03, 32'h0000_0007);
        bus_op(1'b1, 1'b0, 24'h03, 32'h0000_0007);
        for (int unsigned a = 0; a < NCH; a++) bus_op(1'b0, 1'b1, AW'(a), '0);

        // Hole accesses
        bus_op(1'b0, 1'b1, 24'h05, '0);
        bus_op(1'b1, 1'b0, 24'h05, 32'hFFFF_FFFF);
        bus_op(1'b0, 1'b1, 24'h07, '0);
        bus_op(1'b0, 1'b1, 24'h01, '0);

        // Outside the window: no effect at all
        bus_op(1'b0, 1'b1, 24'h28, '0);
        bus_op(1'b1, 1'b0, 24'h28, 32'h0000_0011);
        bus_op(1'b0, 1'b1, 24'hFF_FFFF, '0);
        bus_op(1'b0, 1'b1, 24'h27, '0);

        // Write and read strobes together act as a write only
        bus_op(1'b1, 1'b1, 24'h10, 32'h0000_0033);
        bus_op(1'b0, 1'b1, 24'h10, '0);
        idle(3);

        // Read in flight when reset arrives: RD=3 copy must never complete it
        bus_op(1'b0, 1'b1, 24'h0A, '0);
        do_reset();
        idle(4);
        bus_op(1'b0, 1'b1, 24'h09, '0);
        idle(3);

        // Mixed random traffic, window plus a little beyond it
        for (int unsigned i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            logic          w;
            a = AW'($urandom_range(0, 47));
            w = 1'($urandom_range(0, 2) == 0);
            usr_chan = 2'($urandom_range(0, 3));
            usr_addr = 3'($urandom_range(0, 7));
            bus_op(w, 1'($urandom_range(0, 1)) | ~w, a, $urandom());
        end
        idle(4);

`ifdef GB_CHAN_BANK_SHADOW_EN
        // Commit alongside a CSR write publishes the pre-write shadow; next commit publishes the write
        bus_op(1'b1, 1'b0, 24'h01, 32'h0000_0003, 1'b1);
        bus_op(1'b0, 1'b1, 24'h01, '0);
        bus_op(1'b0, 1'b0, '0, '0, 1'b1);
        check_eq("shadow_commit_csr1", csr1[7:4], 4'h3);
        idle(3);
`endif

        check_eq("q1_drained", q1.size(), 0);
        check_eq("q3_drained", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_chan_bank.md
GB_CHAN_BANK -- requirements
Module: gb_chan_bank

Interface
REQ-001 SHALL have parameter AW, default 24, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have parameter NCH, default 4, channel count, 1..16, NCH <= 2**RAM_AW.
REQ-004 SHALL have parameter CSR_W, default 4, per-channel CSR width, 1..DW.
REQ-005 SHALL have parameter CSR_INIT, default 4'hc, CSR reset value.
REQ-006 SHALL have parameter RAM_AW, default 3, per-channel RAM address width, 2..10.
REQ-007 SHALL have parameter RAM_DW, default 8, per-channel RAM data width, 1..DW.
REQ-008 SHALL have parameter BASE, default 0, window base, aligned to 2**(RAM_AW+5).
REQ-009 SHALL have parameter RD, default 1, read latency in cycles, 1..4.
REQ-010 SHALL have port gb_clk, input, 1, sole clock, all logic on rising edge.
REQ-011 SHALL have port gb_rst, input, 1, reset, synchronous, active-high.
REQ-012 SHALL have ports gb_addr (in, AW), gb_wdata (in, DW), gb_wen (in, 1, write strobe), gb_rstb (in, 1, read strobe).
REQ-013 SHALL have ports gb_rdata (out, DW) and gb_rvalid (out, 1, read data valid pulse).
REQ-014 SHALL have port bus_err, output, 1, pulse on access to an unmapped hole inside the window.
REQ-015 SHALL have ports csr_out (out, NCH*CSR_W, channel n at [n*CSR_W+:CSR_W]) and csr_stb (out, NCH, per-channel update pulse).
REQ-016 SHALL have ports usr_chan (in, clog2(NCH) min 1), usr_addr (in, RAM_AW) and usr_rdata (out, RAM_DW): user-side RAM read port.

Function
REQ-017 SHALL decode the map relative to BASE: CSR n at offset n; RAM n word i at offset (n+1)*2**RAM_AW + i; every other offset below (NCH+1)*2**RAM_AW is a hole.
REQ-018 SHALL ignore accesses outside [BASE, BASE+(NCH+1)*2**RAM_AW): no write, no gb_rvalid, no bus_err.
REQ-019 SHALL on a write (gb_wen) to CSR n store gb_wdata[CSR_W-1:0] in the cycle after the edge; upper bits dropped.
REQ-020 SHALL on a write to RAM n word i store gb_wdata[RAM_DW-1:0], visible to a read starting the next cycle.
REQ-021 SHALL on a read (gb_rstb with gb_wen low) return zero-extended data on gb_rdata with gb_rvalid high exactly RD cycles after the strobe edge.
REQ-022 SHALL accept one read per cycle back-to-back; RD-stage pipeline, no stalls, no drops.
REQ-023 SHALL hold gb_rdata at its last value and gb_rvalid low when no read completes.
REQ-024 SHALL treat gb_wen and gb_rstb high together as a write only: no read, no gb_rvalid.
REQ-025 SHALL on a read of a hole return 0 with gb_rvalid after RD cycles, and pulse bus_err one cycle after the strobe; a write to a hole pulses bus_err and changes nothing.
REQ-026 SHALL return RAM[usr_chan][usr_addr] on usr_rdata one cycle later; usr_chan >= NCH returns 0.
REQ-027 SHALL return on a same-cycle bus write and usr read of one word the old data.
REQ-028 SHALL pulse csr_stb[n] one cycle when csr_out channel n updates, even if unchanged.

Reset
REQ-029 SHALL in the cycle after gb_rst high set every CSR and csr_out channel to CSR_INIT, gb_rdata to 0, and gb_rvalid, bus_err, csr_stb to 0.
REQ-030 SHALL flush the read pipeline on reset; reads in flight never assert gb_rvalid; RAM contents unaffected.
REQ-031 SHALL have gb_rst dominate same-cycle bus accesses: writes dropped, reads discarded.

Configuration
REQ-032 SHALL with GB_CHAN_BANK_SHADOW_EN defined add input commit (1 bit): CSR writes go to per-channel shadow registers; commit high copies all shadows to csr_out next cycle and pulses csr_stb for every channel; bus reads return shadow values.
REQ-033 SHALL with GB_CHAN_BANK_SHADOW_EN defined, on commit and a CSR write in the same cycle, commit the pre-write shadow value; the new value awaits the next commit.
REQ-034 SHALL without GB_CHAN_BANK_SHADOW_EN have no commit port and drive csr_out directly from the CSR registers (REQ-019, REQ-028).

Verification
REQ-035 SHALL cover: reset, then read CSR 2 at BASE+2 with RD=1 -> gb_rdata=0x0000000c, gb_rvalid one cycle later.
REQ-036 SHALL cover: write 0x5A to RAM 3 word 7 (offset 0x27), read next cycle -> 0x0000005A after RD; usr_chan=3, usr_addr=7 -> usr_rdata=0x5A.
REQ-037 SHALL cover: RD=3, reads every cycle to offsets 0x08..0x0F -> eight consecutive gb_rvalid pulses, data in order.
REQ-038 SHALL cover: read hole offset 0x05 with NCH=4 -> bus_err pulse, gb_rdata=0 with gb_rvalid; write to 0x05 changes no state.
REQ-039 SHALL cover: read issued, gb_rst high on the next cycle with RD=3 -> gb_rvalid never asserts; csr_out = CSR_INIT repeated.
REQ-040 SHALL cover with GB_CHAN_BANK_SHADOW_EN: write 0x3 to CSR 1 alongside commit -> csr_out[7:4] unchanged; next commit -> 0x3, csr_stb=4'b1111 one cycle.
